// File: rtl/banked_image_memory_if.sv
// Host access bus for banked_image_memory.
//   enable       : global access enable (host -> memory)
//   write_enable : write request (host -> memory)
//   read_enable  : read request (host -> memory)
//   address      : {bank select, word address} (host -> memory)
//   input_data   : write data (host -> memory)
//   output_data  : registered read data (memory -> host)
//   read_valid   : one-cycle pulse marking new output_data (memory -> host)
//   ready        : host accesses accepted this cycle (memory -> host)
interface banked_image_memory_if #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BANK_ADDR_W = 14,
  parameter int unsigned BANK_SEL_W  = 1
);
  logic                          enable;
  logic                          write_enable;
  logic                          read_enable;
  logic [BANK_SEL_W+BANK_ADDR_W-1:0] address;
  logic [DATA_W-1:0]             input_data;
  logic [DATA_W-1:0]             output_data;
  logic                          read_valid;
  logic                          ready;

  modport master (
    output enable,
    output write_enable,
    output read_enable,
    output address,
    output input_data,
    input  output_data,
    input  read_valid,
    input  ready
  );

  modport slave (
    input  enable,
    input  write_enable,
    input  read_enable,
    input  address,
    input  input_data,
    output output_data,
    output read_valid,
    output ready
  );
endinterface

// File: rtl/banked_image_memory.sv
// Banked image memory: NUM_BANKS single-port arrays with a registered, read-first read path
// and an optional clear engine that fills one bank with CLEAR_VALUE, one word per cycle.
//
// Build option: define BANKED_MEM_CLEAR_EN to include the clear engine. Without it no FSM or
// counter exists, clear_start/clear_bank are ignored, ready is 1 and clear_done is 0.
//
// Ports:
//   clk         : rising-edge clock for all state
//   rst_n       : synchronous active-low reset (array contents are not reset)
//   bus         : host access bus (slave side), see banked_image_memory_if
//   clear_start : single-cycle request to fill one bank (honoured only while idle)
//   clear_bank  : bank to fill, sampled with clear_start
//   clear_done  : one-cycle pulse when a fill completes
module banked_image_memory #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       BANK_ADDR_W = 14,
  parameter int unsigned       BANK_SEL_W  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  banked_image_memory_if.slave  bus,
  input  logic                  clear_start,
  input  logic [BANK_SEL_W-1:0] clear_bank,
  output logic                  clear_done
);

  localparam int unsigned NUM_BANKS = 2 ** BANK_SEL_W;
  localparam int unsigned DEPTH     = 2 ** BANK_ADDR_W;

  logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];

  logic [BANK_SEL_W-1:0]  host_bank;
  logic [BANK_ADDR_W-1:0] host_word;
  logic                   ready;
  logic                   host_ok;
  logic                   host_wr;
  logic                   host_rd;

  // Clear-engine write port; tied off when the engine is not built.
  logic                   clr_wr;
  logic                   clr_wr_en;
  logic [BANK_SEL_W-1:0]  clr_bank_q;
  logic [BANK_ADDR_W-1:0] cnt_q;

  logic [DATA_W-1:0]      rd_data_q;
  logic                   rd_valid_q;

  assign host_bank = bus.address[BANK_SEL_W+BANK_ADDR_W-1 -: BANK_SEL_W];
  assign host_word = bus.address[BANK_ADDR_W-1:0];

  // Nothing is accepted while reset is asserted.
  assign host_ok   = rst_n & bus.enable & ready;
  assign host_wr   = host_ok & bus.write_enable;
  assign host_rd   = host_ok & bus.read_enable;
  assign clr_wr_en = clr_wr & rst_n;

  // Host and clear writes never collide: host writes need ready, which is low while clearing.
  always_ff @(posedge clk) begin
    if (host_wr) begin
      mem_q[host_bank][host_word] <= bus.input_data;
    end else if (clr_wr_en) begin
      mem_q[clr_bank_q][cnt_q] <= CLEAR_VALUE;
    end
  end

  // Non-blocking read of the array alongside a same-edge write gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= host_rd;
      if (host_rd) begin
        rd_data_q <= mem_q[host_bank][host_word];
      end
    end
  end

  assign bus.output_data = rd_data_q;
  assign bus.read_valid  = rd_valid_q;
  assign bus.ready       = ready;

`ifdef BANKED_MEM_CLEAR_EN

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e                 state_q, state_d;
  logic [BANK_ADDR_W-1:0] cnt_d;
  logic [BANK_SEL_W-1:0]  clr_bank_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_bank_q <= clr_bank_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_bank_d = clr_bank_q;
    clr_wr     = 1'b0;
    clear_done = 1'b0;
    ready      = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (clear_start) begin
          clr_bank_d = clear_bank;
          cnt_d      = '0;
          state_d    = StClear;
        end
      end
      StClear: begin
        clr_wr = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // Last word is written on this cycle; counter wraps back to 0.
        if (cnt_q == '1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        clear_done = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`else

  logic unused_clear;

  assign ready        = 1'b1;
  assign clear_done   = 1'b0;
  assign clr_wr       = 1'b0;
  assign clr_bank_q   = '0;
  assign cnt_q        = '0;
  assign unused_clear = ^{clear_start, clear_bank};

`endif

endmodule

// File: tb/tb_banked_image_memory.sv
// Directed bench for banked_image_memory (DATA_W=16, BANK_ADDR_W=4, BANK_SEL_W=1).
// Clear-engine scenarios run when BANKED_MEM_CLEAR_EN is defined; otherwise the
// disabled-engine behaviour is checked.
module tb_banked_image_memory;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_start = 1'b0;
  logic [SW-1:0] clear_bank = '0;
  logic          clear_done;

  int vectors = 0;
  int miscompares = 0;

  banked_image_memory_if #(.DATA_W(DW), .BANK_ADDR_W(AW), .BANK_SEL_W(SW)) bus ();

  banked_image_memory #(
    .DATA_W      (DW),
    .BANK_ADDR_W (AW),
    .BANK_SEL_W  (SW),
    .CLEAR_VALUE (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear_start (clear_start),
    .clear_bank  (clear_bank),
    .clear_done  (clear_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.enable       = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    clear_start      = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [15:0] data);
    bus.enable       = 1'b1;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b0;
    bus.address      = addr;
    bus.input_data   = data;
    tick();
    idle();
  endtask

  task automatic rd(input logic [4:0] addr, input logic [15:0] exp, input string tag);
    bus.enable       = 1'b1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b1;
    bus.address      = addr;
    tick();
    idle();
    check({tag, ".valid"}, {15'd0, bus.read_valid}, 16'd1);
    check({tag, ".data"}, bus.output_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_ready;
    int bad_done;
    int seen;
    bus.address    = '0;
    bus.input_data = '0;
    idle();

    // Reset state.
    tick();
    tick();
    check("rst.output_data", bus.output_data, 16'h0000);
    check("rst.read_valid", {15'd0, bus.read_valid}, 16'd0);
    check("rst.clear_done", {15'd0, clear_done}, 16'd0);
    rst_n = 1'b1;
    tick();
    check("rst.ready", {15'd0, bus.ready}, 16'd1);

    // Bank-separated writes and reads.
    wr(5'h03, 16'hA5A5);
    wr(5'h13, 16'h5A5A);
    rd(5'h03, 16'hA5A5, "basic.b0");
    rd(5'h13, 16'h5A5A, "basic.b1");
    tick();
    check("hold.read_valid", {15'd0, bus.read_valid}, 16'd0);
    check("hold.output_data", bus.output_data, 16'h5A5A);

    // Read-first on simultaneous read/write to one address.
    wr(5'h07, 16'h1234);
    bus.enable       = 1'b1;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    bus.address      = 5'h07;
    bus.input_data   = 16'hBEEF;
    tick();
    idle();
    check("rfirst.valid", {15'd0, bus.read_valid}, 16'd1);
    check("rfirst.data", bus.output_data, 16'h1234);
    rd(5'h07, 16'hBEEF, "rfirst.after");

    // Accesses with enable=0 are dropped.
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    bus.address      = 5'h03;
    bus.input_data   = 16'h0000;
    tick();
    idle();
    check("noen.read_valid", {15'd0, bus.read_valid}, 16'd0);
    rd(5'h03, 16'hA5A5, "noen.keep");

    // Accesses during reset are ignored; reset clears output_data only.
    rst_n            = 1'b0;
    bus.enable       = 1'b1;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    bus.address      = 5'h03;
    bus.input_data   = 16'hFFFF;
    clear_start      = 1'b1;
    clear_bank       = 1'b0;
    tick();
    idle();
    check("rstacc.read_valid", {15'd0, bus.read_valid}, 16'd0);
    check("rstacc.output_data", bus.output_data, 16'h0000);
    rst_n = 1'b1;
    tick();
    check("rstacc.ready", {15'd0, bus.ready}, 16'd1);
    rd(5'h03, 16'hA5A5, "rstacc.keep");

`ifdef BANKED_MEM_CLEAR_EN
    // Fill bank 1.
    for (int i = 0; i < 32; i++) wr(5'(i), 16'hFFFF);
    clear_start = 1'b1;
    clear_bank  = 1'b1;
    tick();
    idle();
    bad_ready = 0;
    bad_done  = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.ready !== 1'b0) bad_ready++;
      if (clear_done !== 1'b0) bad_done++;
      tick();
    end
    check("fill.ready_low_cycles", 16'(bad_ready), 16'd0);
    check("fill.early_done", 16'(bad_done), 16'd0);
    check("fill.clear_done", {15'd0, clear_done}, 16'd1);
    tick();
    check("fill.done_pulse", {15'd0, clear_done}, 16'd0);
    check("fill.ready_back", {15'd0, bus.ready}, 16'd1);
    for (int i = 0; i < 16; i++) rd(5'(i), 16'hFFFF, $sformatf("fill.b0[%0d]", i));
    for (int i = 16; i < 32; i++) rd(5'(i), 16'h0000, $sformatf("fill.b1[%0d]", i - 16));

    // Fill of bank 0 interrupted by reset at counter 6.
    for (int i = 0; i < 16; i++) wr(5'(i), 16'h1000 + 16'(i));
    clear_start = 1'b1;
    clear_bank  = 1'b0;
    tick();
    idle();
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("intr.ready", {15'd0, bus.ready}, 16'd1);
    for (int i = 0; i < 6; i++) rd(5'(i), 16'h0000, $sformatf("intr.cleared[%0d]", i));
    for (int i = 6; i < 16; i++) rd(5'(i), 16'h1000 + 16'(i), $sformatf("intr.kept[%0d]", i));

    // Host write and clear_start during CLEAR are dropped.
    wr(5'h13, 16'h5A5A);
    clear_start = 1'b1;
    clear_bank  = 1'b0;
    tick();
    bus.enable       = 1'b1;
    bus.write_enable = 1'b1;
    bus.address      = 5'h02;
    bus.input_data   = 16'h7777;
    clear_start      = 1'b1;
    clear_bank       = 1'b1;
    tick();
    idle();
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      if (clear_done === 1'b1) seen = 1;
      else tick();
    end
    check("busy.clear_done_seen", 16'(seen), 16'd1);
    tick();
    bad_ready = 0;
    bad_done  = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready !== 1'b1) bad_ready++;
      if (clear_done !== 1'b0) bad_done++;
      tick();
    end
    check("busy.no_second_fill", 16'(bad_ready), 16'd0);
    check("busy.no_second_done", 16'(bad_done), 16'd0);
    rd(5'h02, 16'h0000, "busy.dropped_write");
    rd(5'h13, 16'h5A5A, "busy.other_bank");
`else
    // Clear engine absent: clear_start has no effect.
    clear_start = 1'b1;
    clear_bank  = 1'b0;
    tick();
    idle();
    bad_ready = 0;
    bad_done  = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready !== 1'b1) bad_ready++;
      if (clear_done !== 1'b0) bad_done++;
      tick();
    end
    check("noclr.ready_drops", 16'(bad_ready), 16'd0);
    check("noclr.done_pulses", 16'(bad_done), 16'd0);
    rd(5'h03, 16'hA5A5, "noclr.b0");
    rd(5'h07, 16'hBEEF, "noclr.b0w7");
    rd(5'h13, 16'h5A5A, "noclr.b1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/banked_image_memory.md
BANKED_IMAGE_MEMORY -- requirements
Module: banked_image_memory

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter BANK_ADDR_W, default 14, word-address width inside one bank; bank depth is 2^BANK_ADDR_W.
REQ-003 Parameter BANK_SEL_W, default 1, bank-select width; NUM_BANKS = 2^BANK_SEL_W.
REQ-004 Parameter CLEAR_VALUE, default 0, DATA_W-bit fill word used by the clear engine.
REQ-005 Port clk, input, 1, single rising-edge clock for all state.
REQ-006 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 Port enable, input, 1, global access enable.
REQ-008 Port write_enable, input, 1, write request.
REQ-009 Port read_enable, input, 1, read request.
REQ-010 Port address, input, BANK_SEL_W+BANK_ADDR_W, upper BANK_SEL_W bits select the bank and lower bits the word.
REQ-011 Port input_data, input, DATA_W, write data.
REQ-012 Port output_data, output, DATA_W, registered read data.
REQ-013 Port read_valid, output, 1, one-cycle pulse marking new output_data.
REQ-014 Port ready, output, 1, high when host accesses are accepted.
REQ-015 Port clear_start, input, 1, single-cycle request to fill one bank.
REQ-016 Port clear_bank, input, BANK_SEL_W, bank to fill, sampled with clear_start.
REQ-017 Port clear_done, output, 1, one-cycle pulse when a fill completes.

Function
REQ-018 The block SHALL hold NUM_BANKS independent single-port arrays, each 2^BANK_ADDR_W words of DATA_W bits.
REQ-019 The block SHALL accept a host access only on cycles with enable=1 and ready=1; accesses on other cycles SHALL be dropped with no state change.
REQ-020 An accepted write SHALL update only the bank addressed by address[top BANK_SEL_W bits], at the rising edge of the same cycle.
REQ-021 An accepted read SHALL drive output_data with the addressed word and read_valid=1 exactly one cycle later.
REQ-022 A read and a write accepted together to the same address SHALL return the old word (read-first).
REQ-023 output_data SHALL hold its last value when read_valid=0.
REQ-024 The clear FSM SHALL have states IDLE, CLEAR and DONE; ready=1 only in IDLE.
REQ-025 In IDLE, clear_start=1 SHALL latch clear_bank, zero a BANK_ADDR_W-bit counter and enter CLEAR; a host access in the same cycle SHALL still be accepted.
REQ-026 In CLEAR, each cycle SHALL write CLEAR_VALUE to the latched bank at the counter value and then increment the counter.
REQ-027 When the counter reaches 2^BANK_ADDR_W-1, the FSM SHALL write that last word and go to DONE; a fill takes exactly 2^BANK_ADDR_W cycles.
REQ-028 DONE SHALL assert clear_done for one cycle and return to IDLE.
REQ-029 clear_start outside IDLE SHALL be ignored.
REQ-030 Banks other than the latched bank SHALL be unchanged by a fill.

Reset
REQ-031 On a rising edge with rst_n=0: FSM to IDLE, counter to 0, output_data to 0, read_valid to 0, clear_done to 0; ready SHALL read 1 from the next cycle.
REQ-032 Reset SHALL NOT alter array contents; a fill interrupted by reset SHALL leave the words already written cleared and the rest untouched.
REQ-033 Accesses and clear_start presented while rst_n=0 SHALL be ignored.

Configuration
REQ-034 Macro BANKED_MEM_CLEAR_EN defined: the clear engine (REQ-024..REQ-030) SHALL be built in.
REQ-035 Macro BANKED_MEM_CLEAR_EN undefined: no FSM or counter SHALL be built; clear_start and clear_bank SHALL be ignored; ready SHALL be constant 1 and clear_done constant 0.

Verification (DATA_W=16, BANK_ADDR_W=4, BANK_SEL_W=1, CLEAR_VALUE=16'h0000)
REQ-036 Write 16'hA5A5 to address 5'h03 and 16'h5A5A to address 5'h13, then read both -> 16'hA5A5 and 16'h5A5A, each with read_valid one cycle after the request.
REQ-037 Write 16'h1234 to address 5'h07, then in one cycle write 16'hBEEF to 5'h07 and read 5'h07 -> output_data=16'h1234; a following read -> 16'hBEEF.
REQ-038 Fill all 32 words with 16'hFFFF, pulse clear_start with clear_bank=1 -> ready=0 for 16 cycles, then clear_done for one cycle; bank 1 reads 16'h0000 and bank 0 reads 16'hFFFF.
REQ-039 Start a fill of bank 0 and assert rst_n=0 at counter value 6 -> words 0..5 read 16'h0000, words 6..15 keep their old values, ready=1 after reset.
REQ-040 During CLEAR, write 16'h7777 to 5'h02 and pulse clear_start -> write dropped and no second fill; after clear_done, 5'h02 reads CLEAR_VALUE.
REQ-041 Build without BANKED_MEM_CLEAR_EN and pulse clear_start -> ready stays 1, clear_done stays 0 and contents are unchanged.
